canonical_term_unit: RTL
========================

# canonical_term_unit

Parametrised, loadable successor to the fixed 4-input product-of-sums block. It holds a 2^N_IN-entry truth-table mask, interpreted as a minterm list (SOP) or a maxterm list (POS). It evaluates input vectors with registered output and counts the function's maxterms with a sequential scan. It sits beside the combinational canonical-form exercises as a reusable, runtime-programmable logic function unit.

## Interface
- N_IN, 4, number of input variables; index = {in_vars[N_IN-1] (A, MSB) … in_vars[0] (LSB)}
- LOAD_W, 8, load word width; TW = 2**N_IN must be a multiple of LOAD_W (derived localparam TW, NWORDS = TW/LOAD_W)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse: abort current activity, latch mode, begin table load
- mode  in  1  0 = SOP (mask bit 1 ⇒ F=1), 1 = POS (mask bit 1 ⇒ F=0); sampled only with load_start
- load_valid  in  1  load word valid
- load_ready  out  1  unit accepts load word
- load_data  in  LOAD_W  mask bits; word k carries mask[k*LOAD_W +: LOAD_W]
- in_valid  in  1  evaluation request
- in_ready  out  1  evaluation accepted this cycle
- in_vars  in  N_IN  variable vector
- out_valid  out  1  out_f valid
- out_f  out  1  F(in_vars)
- term_count  out  N_IN+1  number of indices with F=0
- count_valid  out  1  term_count valid for the committed table

## Operation
- States: IDLE (no table), LOAD, SCAN, READY.
- IDLE→LOAD on load_start. load_start in any state → LOAD: word counter cleared, mask cleared, count_valid/out_valid cleared, mode_q ← mode.
- LOAD: load_ready=1; a word is accepted when load_valid&&load_ready, written at the word counter, counter++. Accepting word NWORDS-1 commits the table → SCAN.
- SCAN: index 0..TW-1, one bit per cycle; accumulator += (F(index)==0). After index TW-1 → READY, term_count ← accumulator, count_valid=1.
- F(x) = mode_q ? ~mask[x] : mask[x].
- in_ready = (state ∈ {SCAN, READY}) && !load_start. Evaluations are legal during SCAN.
- load_start with in_valid in the same cycle: load wins, no evaluation accepted. load_start with load_valid: restart; the word is not written.
- Out-of-order or extra load words are impossible: load_ready=0 outside LOAD.
- term_count range 0..TW inclusive; the N_IN+1 width prevents overflow at all-zero F.

## Timing
- Reset: state IDLE, mask 0, mode_q 0, load_ready 0, in_ready 0, out_valid 0, out_f 0, term_count 0, count_valid 0.
- Evaluation latency 1: request accepted at edge t ⇒ out_valid=1, out_f valid for cycle t+1; out_valid=0 the cycle after unless another request is accepted; full throughput of one per cycle.
- Last load word accepted at edge t ⇒ SCAN during cycles t+1..t+TW, READY with count_valid=1 from t+TW+1.
- Load of NWORDS words with continuous load_valid takes NWORDS cycles.
- Reset asserted mid-load or mid-scan: immediate return to reset values; the partial table is discarded.

## Structure
- Package canonical_pkg: state enum (IDLE, LOAD, SCAN, READY), MODE_SOP=1'b0, MODE_POS=1'b1.
- Sub-module term_scanner: index counter plus zero-count accumulator. It takes start, mask and mode_q, and returns done and count. The top holds the FSM, the load path and the evaluation register.

## Test plan
- POS load of the legacy 4-input function (maxterms 0,1,4,6,8,12,14,15): mode=1, words 0x53, 0xD1 → count_valid after 16 scan cycles with term_count=8; sweep all 16 in_vars → out_f=0 exactly at those indices and 1 elsewhere, each one cycle after acceptance.
- Same words with mode=0 (SOP) → term_count=8, out_f inverted relative to the POS case at every index.
- All-zero mask in SOP → term_count=16 (MSB set, no wrap). All-zero mask in POS → term_count=0.
- Back-to-back in_valid during SCAN → in_ready=1, one result per cycle, count_valid only after scan completes.
- load_start while in_valid=1 in READY → in_ready=0, no out_valid next cycle, count_valid drops, load_ready=1.
- rst_n pulled low after one load word → all outputs at reset values; IDLE with in_ready=0 until a new load completes.

Source files
------------

// File: rtl/canonical_pkg.sv
// rtl/canonical_pkg.sv - shared state encoding, mode constants and term evaluation helper
package canonical_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        READY = 2'd3
    } state_e;

    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

    // In POS mode a set mask bit marks a maxterm, so the function is 0 there.
    function automatic logic eval_f(input logic mask_bit, input logic mode);
        return (mode == MODE_POS) ? ~mask_bit : mask_bit;
    endfunction

endpackage

// File: rtl/term_scanner.sv
// rtl/term_scanner.sv - sequential scan of the truth table counting indices where F is 0
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     begin a scan at index 0 on the next cycle
//   abort_i     drop any scan in progress
//   mask_i      committed truth-table mask
//   mode_i      0 = SOP, 1 = POS
//   done_o      high in the cycle the last index is examined
//   count_o     running zero count including the index examined this cycle
module term_scanner
    import canonical_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [2**N_IN-1:0] mask_i,
    input  logic              mode_i,
    output logic              done_o,
    output logic [N_IN:0]     count_o
);

    logic            busy_q;
    logic [N_IN-1:0] idx_q;
    logic [N_IN:0]   acc_q;
    logic            zero_here;

    assign zero_here = busy_q && !eval_f(mask_i[idx_q], mode_i);
    // Both are combinational so the owner can commit the count on the same
    // edge that retires the last index.
    assign done_o    = busy_q && (&idx_q);
    assign count_o   = acc_q + {{N_IN{1'b0}}, zero_here};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            acc_q  <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            acc_q  <= '0;
        end else if (busy_q) begin
            acc_q <= count_o;
            idx_q <= idx_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/canonical_term_unit.sv
// rtl/canonical_term_unit.sv - loadable SOP/POS truth-table function unit with maxterm count
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   load_start, mode       restart a table load and latch SOP/POS mode
//   load_valid/ready/data  mask words, lowest word first
//   in_valid/ready, in_vars evaluation requests
//   out_valid, out_f       registered F(in_vars), one cycle after acceptance
//   term_count, count_valid number of indices with F=0 for the committed table
module canonical_term_unit
    import canonical_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int LOAD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              mode,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [LOAD_W-1:0] load_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_vars,
    output logic              out_valid,
    output logic              out_f,
    output logic [N_IN:0]     term_count,
    output logic              count_valid
);

    localparam int TW     = 2**N_IN;
    localparam int NWORDS = TW / LOAD_W;
    localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_e          state_q;
    logic [WCW-1:0]  wcnt_q;
    logic [TW-1:0]   mask_q;
    logic            mode_q;
    logic            load_ready_q;
    logic            out_valid_q;
    logic            out_f_q;
    logic [N_IN:0]   term_count_q;
    logic            count_valid_q;

    logic            word_acc;
    logic            last_word;
    logic            eval_acc;
    logic            scan_done;
    logic [N_IN:0]   scan_count;

    // load_start has priority over both the load and evaluation handshakes.
    assign word_acc  = load_ready_q && load_valid && !load_start;
    assign last_word = word_acc && (wcnt_q == WCW'(NWORDS - 1));
    assign in_ready  = ((state_q == SCAN) || (state_q == READY)) && !load_start;
    assign eval_acc  = in_valid && in_ready;

    assign load_ready  = load_ready_q;
    assign out_valid   = out_valid_q;
    assign out_f       = out_f_q;
    assign term_count  = term_count_q;
    assign count_valid = count_valid_q;

    term_scanner #(.N_IN(N_IN)) u_scanner (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (last_word),
        .abort_i (load_start),
        .mask_i  (mask_q),
        .mode_i  (mode_q),
        .done_o  (scan_done),
        .count_o (scan_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            mask_q        <= '0;
            mode_q        <= MODE_SOP;
            load_ready_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_f_q       <= 1'b0;
            term_count_q  <= '0;
            count_valid_q <= 1'b0;
        end else begin
            out_valid_q <= eval_acc;
            if (eval_acc) begin
                out_f_q <= eval_f(mask_q[in_vars], mode_q);
            end

            if (load_start) begin
                state_q       <= LOAD;
                wcnt_q        <= '0;
                mask_q        <= '0;
                mode_q        <= mode;
                load_ready_q  <= 1'b1;
                count_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (word_acc) begin
                            mask_q[int'(wcnt_q) * LOAD_W +: LOAD_W] <= load_data;
                            wcnt_q <= wcnt_q + WCW'(1);
                            if (last_word) begin
                                state_q      <= SCAN;
                                load_ready_q <= 1'b0;
                            end
                        end
                    end
                    SCAN: begin
                        if (scan_done) begin
                            state_q       <= READY;
                            term_count_q  <= scan_count;
                            count_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
